// File: rtl/hazard_ctrl_if.sv
// Hazard controller interface: bundles the ID/EX hazard inputs coming from
// the pipeline and the stage enable/flush controls, MDU handshake and
// performance counters returned by the controller.
//   master : pipeline side, drives the hazard inputs, consumes the controls
//   slave  : hazard_ctrl_unit side
// Ports carried:
//   rs1_id, rs2_id, use_rs1_id, use_rs2_id   ID operand usage
//   rd_ex, mem_read_ex, branch_taken_ex      EX instruction info
//   mdu_op_ex, mdu_done                      MDU occupancy handshake
//   pc_en, if_id_en, if_id_flush, id_ex_en,
//   id_ex_flush, ex_mem_flush, mdu_start     stage controls
//   mdu_timeout, stall_cnt, flush_cnt        status / counters
interface hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       rs1_id;
   logic [4:0]       rs2_id;
   logic             use_rs1_id;
   logic             use_rs2_id;
   logic [4:0]       rd_ex;
   logic             mem_read_ex;
   logic             branch_taken_ex;
   logic             mdu_op_ex;
   logic             mdu_done;

   logic             pc_en;
   logic             if_id_en;
   logic             if_id_flush;
   logic             id_ex_en;
   logic             id_ex_flush;
   logic             ex_mem_flush;
   logic             mdu_start;
   logic             mdu_timeout;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_ex, mem_read_ex,
             branch_taken_ex, mdu_op_ex, mdu_done,
      input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
             ex_mem_flush, mdu_start, mdu_timeout, stall_cnt, flush_cnt
   );

   modport slave (
      input  rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_ex, mem_read_ex,
             branch_taken_ex, mdu_op_ex, mdu_done,
      output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
             ex_mem_flush, mdu_start, mdu_timeout, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard sequencing controller for the 5-stage core.
// Handles load-use stalls, taken-branch flushes and multi-cycle MDU
// occupancy of EX; keeps stall / flush performance counters.
// Ports:
//   clk  core clock, rising edge
//   rst  synchronous active-high reset
//   hz   hazard_ctrl_if.slave (hazard inputs in, stage controls out)
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_RUN      | normal flow; branch flush > MDU start > load-use bubble
// S_MDU_BUSY | MDU op frozen in EX; wait for mdu_done or busy timeout
module hazard_ctrl_unit #(
   parameter int MDU_MAX_CYC = 64,
   parameter int CNT_W       = 32
) (
   input  logic         clk,
   input  logic         rst,
   hazard_ctrl_if.slave hz
);

   localparam int BW = $clog2(MDU_MAX_CYC + 1);

   typedef enum logic {
      S_RUN      = 1'b0,
      S_MDU_BUSY = 1'b1
   } state_t;

   state_t           state_q, state_nxt;
   logic [BW-1:0]    busy_q, busy_nxt;
   logic             timeout_q, timeout_nxt;
   logic [CNT_W-1:0] stall_q, flush_q;
   logic             flush_evt;
   logic             load_use;

   logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
   logic ex_mem_flush, mdu_start;

   // x0 is hard-wired zero, so a load targeting it never creates a dependency.
   assign load_use = hz.mem_read_ex && (hz.rd_ex != 5'd0) &&
                     ((hz.use_rs1_id && (hz.rs1_id == hz.rd_ex)) ||
                      (hz.use_rs2_id && (hz.rs2_id == hz.rd_ex)));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_RUN;
         busy_q    <= '0;
         timeout_q <= 1'b0;
         stall_q   <= '0;
         flush_q   <= '0;
      end else begin
         state_q   <= state_nxt;
         busy_q    <= busy_nxt;
         timeout_q <= timeout_nxt;
         if (!pc_en)
            stall_q <= stall_q + CNT_W'(1);
         if (flush_evt)
            flush_q <= flush_q + CNT_W'(1);
      end
   end

   always_comb begin
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      id_ex_en     = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      mdu_start    = 1'b0;
      state_nxt    = state_q;
      busy_nxt     = busy_q;
      timeout_nxt  = timeout_q;
      flush_evt    = 1'b0;

      case (state_q)
         S_RUN: begin
            if (hz.branch_taken_ex) begin
               // Wrong-path instructions in IF/ID and ID/EX are squashed;
               // the younger hazards they raised are moot.
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
               flush_evt   = 1'b1;
            end else if (hz.mdu_op_ex) begin
               mdu_start    = 1'b1;
               pc_en        = 1'b0;
               if_id_en     = 1'b0;
               id_ex_en     = 1'b0;
               ex_mem_flush = 1'b1;
               state_nxt    = S_MDU_BUSY;
               busy_nxt     = BW'(1);
            end else if (load_use) begin
               // One bubble suffices: next cycle the load is in MEM and
               // forwarding covers the dependency.
               pc_en       = 1'b0;
               if_id_en    = 1'b0;
               id_ex_flush = 1'b1;
            end
         end

         S_MDU_BUSY: begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_flush = 1'b1;
            if (hz.mdu_done) begin
               // Release in the done cycle so the result is captured in EX/MEM.
               pc_en        = 1'b1;
               if_id_en     = 1'b1;
               id_ex_en     = 1'b1;
               ex_mem_flush = 1'b0;
               state_nxt    = S_RUN;
               busy_nxt     = '0;
            end else if (busy_q == BW'(MDU_MAX_CYC)) begin
               // Give up on the MDU: the pipeline moves on, but the bogus
               // result is kept out of EX/MEM by the still-asserted bubble.
               pc_en       = 1'b1;
               if_id_en    = 1'b1;
               id_ex_en    = 1'b1;
               timeout_nxt = 1'b1;
               state_nxt   = S_RUN;
               busy_nxt    = '0;
            end else begin
               busy_nxt = busy_q + BW'(1);
            end
         end

         default: state_nxt = S_RUN;
      endcase
   end

   assign hz.pc_en        = pc_en;
   assign hz.if_id_en     = if_id_en;
   assign hz.if_id_flush  = if_id_flush;
   assign hz.id_ex_en     = id_ex_en;
   assign hz.id_ex_flush  = id_ex_flush;
   assign hz.ex_mem_flush = ex_mem_flush;
   assign hz.mdu_start    = mdu_start;
   assign hz.mdu_timeout  = timeout_q;
   assign hz.stall_cnt    = stall_q;
   assign hz.flush_cnt    = flush_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
module tb_hazard_ctrl_unit;

   localparam int MAXC = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   hazard_ctrl_if #(.CNT_W(32)) hz ();

   hazard_ctrl_unit #(.MDU_MAX_CYC(MAXC), .CNT_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz)
   );

   typedef struct {
      logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
      logic        ex_mem_flush, mdu_start, mdu_timeout;
      logic [31:0] stall_cnt, flush_cnt;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: "is the MDU still holding EX", how many cycles it has
   // waited, the sticky error and the two event tallies.
   bit          m_busy;
   int          m_wait;
   bit          m_to;
   logic [31:0] m_stall, m_flush;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
      end
   endtask

   // One clock cycle of stimulus; expected response goes to the scoreboard.
   task automatic cyc(input bit r, input logic [4:0] rs1, input logic [4:0] rs2,
                      input bit u1, input bit u2, input logic [4:0] rd,
                      input bit mr, input bit bt, input bit mo, input bit md);
      exp_t e;
      bit   lu;
      @(posedge clk);
      #1;
      rst                = r;
      hz.rs1_id          = rs1;
      hz.rs2_id          = rs2;
      hz.use_rs1_id      = u1;
      hz.use_rs2_id      = u2;
      hz.rd_ex           = rd;
      hz.mem_read_ex     = mr;
      hz.branch_taken_ex = bt;
      hz.mdu_op_ex       = mo;
      hz.mdu_done        = md;
      if (r) begin
         m_busy = 0; m_wait = 0; m_to = 0; m_stall = 0; m_flush = 0;
         return;
      end
      e.pc_en = 1; e.if_id_en = 1; e.id_ex_en = 1;
      e.if_id_flush = 0; e.id_ex_flush = 0; e.ex_mem_flush = 0; e.mdu_start = 0;
      e.mdu_timeout = m_to; e.stall_cnt = m_stall; e.flush_cnt = m_flush;
      lu = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      if (!m_busy) begin
         if (bt) begin
            e.if_id_flush = 1; e.id_ex_flush = 1;
            m_flush++;
         end else if (mo) begin
            e.mdu_start = 1; e.pc_en = 0; e.if_id_en = 0; e.id_ex_en = 0;
            e.ex_mem_flush = 1;
            m_busy = 1; m_wait = 1;
         end else if (lu) begin
            e.pc_en = 0; e.if_id_en = 0; e.id_ex_flush = 1;
         end
      end else begin
         e.ex_mem_flush = 1;
         if (md) begin
            e.ex_mem_flush = 0;
            m_busy = 0;
         end else if (m_wait == MAXC) begin
            m_to = 1;
            m_busy = 0;
         end else begin
            e.pc_en = 0; e.if_id_en = 0; e.id_ex_en = 0;
            m_wait++;
         end
      end
      if (!e.pc_en) m_stall++;
      exp_q.push_back(e);
   endtask

   task automatic idle();
      cyc(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
   endtask

   // Monitor: compares whatever the DUT presents mid-cycle against the queue.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pc_en",        32'(hz.pc_en),        32'(e.pc_en));
            chk("if_id_en",     32'(hz.if_id_en),     32'(e.if_id_en));
            chk("if_id_flush",  32'(hz.if_id_flush),  32'(e.if_id_flush));
            chk("id_ex_en",     32'(hz.id_ex_en),     32'(e.id_ex_en));
            chk("id_ex_flush",  32'(hz.id_ex_flush),  32'(e.id_ex_flush));
            chk("ex_mem_flush", 32'(hz.ex_mem_flush), 32'(e.ex_mem_flush));
            chk("mdu_start",    32'(hz.mdu_start),    32'(e.mdu_start));
            chk("mdu_timeout",  32'(hz.mdu_timeout),  32'(e.mdu_timeout));
            chk("stall_cnt",    hz.stall_cnt,         e.stall_cnt);
            chk("flush_cnt",    hz.flush_cnt,         e.flush_cnt);
         end
      end
   end

   initial begin
      hz.rs1_id = '0; hz.rs2_id = '0; hz.use_rs1_id = 0; hz.use_rs2_id = 0;
      hz.rd_ex = '0; hz.mem_read_ex = 0; hz.branch_taken_ex = 0;
      hz.mdu_op_ex = 0; hz.mdu_done = 0;

      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle();

      // load-use on rs1, then load has moved to MEM
      cyc(0, 5'd5, 5'd1, 1, 0, 5'd5, 1, 0, 0, 0);
      idle();
      idle();

      // x0 destination and unused rs2 never stall
      cyc(0, 5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, 0);
      cyc(0, 5'd3, 5'd7, 1, 0, 5'd7, 1, 0, 0, 0);
      idle();

      // MDU with done six cycles after the start cycle
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      idle();

      // branch beats a simultaneous load-use and MDU request
      cyc(0, 5'd9, 5'd0, 1, 0, 5'd9, 1, 1, 0, 0);
      cyc(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0);
      idle();

      // timeout, then sticky flag
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < MAXC + 4; i++) idle();
      cyc(0, 5'd2, 5'd2, 1, 1, 5'd2, 1, 1, 0, 0);
      idle();

      // reset mid-MDU, late done ignored
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      idle();
      idle();
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle();
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 299) == 0),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             5'($urandom_range(0, 3)),
             $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
      end
      idle();

      @(negedge clk);
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
